// File: rtl/fallthrough_small_fifo.sv
// ---------------------------------------------------------------------------
// fallthrough_small_fifo
//   Shallow first-word-fall-through FIFO for packet-pipeline input buffering.
//   The head word is presented on dout whenever empty=0, and rd_en pops it.
//   Upstream throttles on nearly_full, which leaves one word of slack.
//
// Ports
//   clk          in            rising-edge clock
//   reset        in            synchronous, active-high
//   din          in  [WIDTH]   write data
//   wr_en        in            push din (ignored while full)
//   rd_en        in            pop head word (ignored while empty)
//   dout         out [WIDTH]   head word, valid while empty=0
//   full         out           occupancy == depth
//   nearly_full  out           occupancy >= depth-1
//   prog_full    out           occupancy >= PROG_FULL_THRESHOLD
//   empty        out           occupancy == 0
//
// Build option
//   FALLTHROUGH_SMALL_FIFO_CHECK_EN : compiles in simulation-only messages for
//   writes to a full FIFO and reads from an empty FIFO. The datapath is the
//   same with or without it.
// ---------------------------------------------------------------------------
module fallthrough_small_fifo #(
    parameter int unsigned WIDTH               = 72,
    parameter int unsigned MAX_DEPTH_BITS      = 3,
    parameter int unsigned PROG_FULL_THRESHOLD = 2**MAX_DEPTH_BITS - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             nearly_full,
    output logic             prog_full,
    output logic             empty
);

    localparam int unsigned DEPTH = 2**MAX_DEPTH_BITS;
    localparam int unsigned PW    = MAX_DEPTH_BITS;
    localparam int unsigned CW    = MAX_DEPTH_BITS + 1;

    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_NFULL = CW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_PROG  = CW'(PROG_FULL_THRESHOLD);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic wr_acc;
    logic rd_acc;

    // Flags are decoded straight from the occupancy counter.
    assign full        = (cnt_q == CNT_FULL);
    assign nearly_full = (cnt_q >= CNT_NFULL);
    assign prog_full   = (cnt_q >= CNT_PROG);
    assign empty       = (cnt_q == '0);

    // The head word falls through combinationally from the read pointer.
    assign dout = mem_q[rp_q];

    // Accept qualification and next-state for the pointers and occupancy.
    always_comb begin
        wr_acc = wr_en && !full;
        rd_acc = rd_en && !empty;
        wp_d   = wp_q;
        rp_d   = rp_q;
        cnt_d  = cnt_q + CW'(wr_acc) - CW'(rd_acc);
        if (wr_acc) begin
            wp_d = wp_q + PW'(1);
        end
        if (rd_acc) begin
            rp_d = rp_q + PW'(1);
        end
    end

    // Pointer and counter state. Reset discards all stored words.
    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage array. Its contents are left alone by reset.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            mem_q[wp_q] <= din;
        end
    end

`ifdef FALLTHROUGH_SMALL_FIFO_CHECK_EN
    // Simulation-only misuse messages.
    always @(posedge clk) begin
        if (!reset) begin
            if (wr_en && full) begin
                $display("%0t ERROR: write to full fifo %m", $time);
            end
            if (rd_en && empty) begin
                $display("%0t ERROR: read from empty fifo %m", $time);
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_fallthrough_small_fifo.sv
// ---------------------------------------------------------------------------
// tb_fallthrough_small_fifo
//   Directed bench for fallthrough_small_fifo with default parameters
//   (WIDTH=72, depth 8, prog_full threshold 7).
// ---------------------------------------------------------------------------
module tb_fallthrough_small_fifo;

    localparam int unsigned WIDTH = 72;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] din;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             nearly_full;
    logic             prog_full;
    logic             empty;

    logic [3:0] flags;
    assign flags = {empty, full, nearly_full, prog_full};

    int checks = 0;
    int errors = 0;

    fallthrough_small_fifo dut (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .dout        (dout),
        .full        (full),
        .nearly_full (nearly_full),
        .prog_full   (prog_full),
        .empty       (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] got,
                         input logic [WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] d);
        din   = d;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    logic [3:0] exp_flags;

    initial begin
        reset = 1'b1;
        din   = '0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Idle after reset: {empty,full,nearly_full,prog_full} = 1000.
        for (int i = 0; i < 3; i++) begin
            check("reset_flags", WIDTH'(flags), WIDTH'(4'b1000));
            tick();
        end

        // Single word falls through right after its write edge.
        push(WIDTH'(72'h11));
        check("single_empty", WIDTH'(empty), WIDTH'(1'b0));
        check("single_dout", dout, WIDTH'(72'h11));
        pop();
        check("single_pop_empty", WIDTH'(empty), WIDTH'(1'b1));

        // Fill to depth 8 with 0..7; flags follow occupancy.
        for (int i = 0; i < 8; i++) begin
            push(WIDTH'(i));
            exp_flags = {1'b0, (i == 7), (i >= 6), (i >= 6)};
            check("fill_flags", WIDTH'(flags), WIDTH'(exp_flags));
        end
        check("fill_head", dout, WIDTH'(0));

        // A write while full is dropped.
        push(WIDTH'(72'hFF));
        check("overflow_flags", WIDTH'(flags), WIDTH'(4'b0111));
        check("overflow_head", dout, WIDTH'(0));

        // Drain: strict order 0..7, then empty.
        for (int i = 0; i < 8; i++) begin
            check("drain_dout", dout, WIDTH'(i));
            pop();
        end
        check("drain_empty_flags", WIDTH'(flags), WIDTH'(4'b1000));

        // Keep 3 words stored and stream read+write for 20 cycles across wrap.
        push(WIDTH'(72'h100));
        push(WIDTH'(72'h101));
        push(WIDTH'(72'h102));
        wr_en = 1'b1;
        rd_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            din = WIDTH'(72'h103 + i);
            check("stream_dout", dout, WIDTH'(72'h100 + i));
            tick();
            check("stream_cnt", WIDTH'(dut.cnt_q), WIDTH'(3));
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stream_tail", dout, WIDTH'(72'h114 + i));
            pop();
        end
        check("stream_empty", WIDTH'(empty), WIDTH'(1'b1));

        // Read while empty is ignored; the next write still reads back.
        pop();
        check("underflow_flags", WIDTH'(flags), WIDTH'(4'b1000));
        push(WIDTH'(72'h55));
        check("underflow_next", dout, WIDTH'(72'h55));
        check("underflow_cnt", WIDTH'(dut.cnt_q), WIDTH'(1));
        pop();
        check("underflow_drain", WIDTH'(empty), WIDTH'(1'b1));

        // Simultaneous read+write while empty: only the write is taken.
        din   = WIDTH'(72'h77);
        wr_en = 1'b1;
        rd_en = 1'b1;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("rw_empty_dout", dout, WIDTH'(72'h77));
        check("rw_empty_cnt", WIDTH'(dut.cnt_q), WIDTH'(1));
        pop();

        // Reset mid-operation discards stored words.
        for (int i = 0; i < 5; i++) begin
            push(WIDTH'(72'h200 + i));
        end
        check("pre_reset_cnt", WIDTH'(dut.cnt_q), WIDTH'(5));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("post_reset_flags", WIDTH'(flags), WIDTH'(4'b1000));
        check("post_reset_cnt", WIDTH'(dut.cnt_q), WIDTH'(0));
        push(WIDTH'(72'hAB));
        check("post_reset_first", dout, WIDTH'(72'hAB));
        pop();
        check("post_reset_empty", WIDTH'(empty), WIDTH'(1'b1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
